multdiv_seq: RTL and testbench

- Iterative signed 32-bit multiply/divide unit, the multi-cycle companion of the single-cycle ALU in the processor execute stage.
- One control pulse latches both operands and starts the operation; result and exception come back later with a one-cycle ready strobe.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with sign fix-up. The same core and datapath registers serve both operations.

---
 rtl/multdiv_seq.sv | 169 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Optional remainder output enabled by defining MULTDIV_REMAINDER_EN.
module multdiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
`ifdef MULTDIV_REMAINDER_EN
    output logic [DATA_WIDTH-1:0] data_remainder,
`endif
    output logic                  data_resultRDY
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state, stateNext;
    logic [CW-1:0]  counter, counterNext;
    // acc is one bit wider than the operands so Booth never overflows on -2^(W-1)
    logic [W:0]     acc, accNext;
    logic [W-1:0]   qReg, qRegNext;
    logic           qm1, qm1Next;
    logic [W-1:0]   mReg, mRegNext;
    logic           negQuot, negQuotNext, negRem, negRemNext;
    logic           divZero, divZeroNext, divOvf, divOvfNext;
    logic [W-1:0]   resultNext;
    logic           excNext, rdyNext;
`ifdef MULTDIV_REMAINDER_EN
    logic [W-1:0]   remNext;
`endif

    logic [W:0]     mExt, boothSum, mulAcc, shAcc, diff, divAcc;
    logic [W-1:0]   mulQ, divQ, absA, absB, quotSigned, remSigned;
    logic [2*W-1:0] product;
    logic           mulOvf;

    assign absA = data_operandA[W-1] ? -data_operandA : data_operandA;
    assign absB = data_operandB[W-1] ? -data_operandB : data_operandB;

    always_comb begin
        mExt = {mReg[W-1], mReg};
        case ({qReg[0], qm1})
            2'b10:   boothSum = acc - mExt;
            2'b01:   boothSum = acc + mExt;
            default: boothSum = acc;
        endcase
        mulAcc  = {boothSum[W], boothSum[W:1]};
        mulQ    = {boothSum[0], qReg[W-1:1]};
        product = {mulAcc[W-1:0], mulQ};
        mulOvf  = !((&product[2*W-1:W-1]) || (~|product[2*W-1:W-1]));

        shAcc  = {acc[W-1:0], qReg[W-1]};
        diff   = shAcc - {1'b0, mReg};
        divAcc = diff[W] ? shAcc : diff;
        divQ   = {qReg[W-2:0], ~diff[W]};
        quotSigned = negQuot ? -divQ : divQ;
        remSigned  = negRem ? -divAcc[W-1:0] : divAcc[W-1:0];
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        accNext     = acc;
        qRegNext    = qReg;
        qm1Next     = qm1;
        mRegNext    = mReg;
        negQuotNext = negQuot;
        negRemNext  = negRem;
        divZeroNext = divZero;
        divOvfNext  = divOvf;
        resultNext  = data_result;
        excNext     = data_exception;
        rdyNext     = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
        remNext     = data_remainder;
`endif
        if (ctrl_MULT || ctrl_DIV) begin
            // A start pulse always wins, aborting whatever is in flight; MULT beats DIV
            stateNext   = ctrl_MULT ? MUL : DIV;
            counterNext = '0;
            accNext     = '0;
            qm1Next     = 1'b0;
            qRegNext    = ctrl_MULT ? data_operandB : absA;
            mRegNext    = ctrl_MULT ? data_operandA : absB;
            negQuotNext = data_operandA[W-1] ^ data_operandB[W-1];
            negRemNext  = data_operandA[W-1];
            divZeroNext = (data_operandB == '0);
            divOvfNext  = (data_operandA == {1'b1, {(W-1){1'b0}}}) && (&data_operandB);
        end else begin
            case (state)
                MUL: begin
                    accNext     = mulAcc;
                    qRegNext    = mulQ;
                    qm1Next     = qReg[0];
                    counterNext = counter + 1'b1;
                    if (counter == CW'(W-1)) begin
                        stateNext   = DONE;
                        counterNext = '0;
                        resultNext  = product[W-1:0];
                        excNext     = mulOvf;
                        rdyNext     = 1'b1;
                    end
                end
                DIV: begin
                    accNext     = divAcc;
                    qRegNext    = divQ;
                    counterNext = counter + 1'b1;
                    if (counter == CW'(W-1)) begin
                        stateNext   = DONE;
                        counterNext = '0;
                        resultNext  = divZero ? '0 : quotSigned;
                        excNext     = divZero || divOvf;
                        rdyNext     = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                        remNext     = (divZero || divOvf) ? '0 : remSigned;
`endif
                    end
                end
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            acc            <= '0;
            qReg           <= '0;
            qm1            <= 1'b0;
            mReg           <= '0;
            negQuot        <= 1'b0;
            negRem         <= 1'b0;
            divZero        <= 1'b0;
            divOvf         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            state          <= stateNext;
            counter        <= counterNext;
            acc            <= accNext;
            qReg           <= qRegNext;
            qm1            <= qm1Next;
            mReg           <= mRegNext;
            negQuot        <= negQuotNext;
            negRem         <= negRemNext;
            divZero        <= divZeroNext;
            divOvf         <= divOvfNext;
            data_result    <= resultNext;
            data_exception <= excNext;
            data_resultRDY <= rdyNext;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= remNext;
`endif
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed operations, latency, restart, priority and reset abort.
module tb_multdiv_seq;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    multdiv_seq #(.DATA_WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
`ifdef MULTDIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    int edgeCount = 0;
    always @(posedge clock) edgeCount++;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] expQ[$];
    logic         expExcQ[$];
    logic [W-1:0] expRemQ[$];
    logic         expDivQ[$];
    int           expEdgeQ[$];
    logic [W-1:0] lastRem = '0;

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every RDY strobe must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy actual=1 expected=0 at edge %0d", edgeCount);
            end else begin
                logic [W-1:0] er, erem;
                logic ee, isDiv;
                int eEdge;
                er = expQ.pop_front();
                ee = expExcQ.pop_front();
                erem = expRemQ.pop_front();
                isDiv = expDivQ.pop_front();
                eEdge = expEdgeQ.pop_front();
                check32("result", data_result, er);
                check32("exception", {31'b0, data_exception}, {31'b0, ee});
                checkInt("latency_edge", edgeCount, eEdge);
                if (isDiv) lastRem = erem;
`ifdef MULTDIV_REMAINDER_EN
                check32("remainder", data_remainder, lastRem);
`endif
            end
        end
    end

    task automatic startOp(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit wantRdy, input logic [W-1:0] er, input logic ee, input logic [W-1:0] erem);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV = d;
        if (wantRdy) begin
            expQ.push_back(er);
            expExcQ.push_back(ee);
            expRemQ.push_back(erem);
            expDivQ.push_back(d & ~m);
            expEdgeQ.push_back(edgeCount + 33);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    task automatic waitDone();
        int budget = 0;
        while (expQ.size() != 0 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=pending expected=rdy");
            expQ.delete(); expExcQ.delete(); expRemQ.delete(); expDivQ.delete(); expEdgeQ.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check32("reset_result", data_result, 32'h0);
        check32("reset_exception", {31'b0, data_exception}, 32'h0);
        check32("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        #10 reset = 1'b0;

        startOp(1, 0, 32'd3, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF4, 0, 0); waitDone();
        startOp(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0, 1, 0); waitDone();
        startOp(1, 0, 32'h8000_0000, 32'd1, 1, 32'h8000_0000, 0, 0); waitDone();
        startOp(1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1, 32'd30, 0, 0); waitDone();
        startOp(1, 0, 32'h7FFF_FFFF, 32'd2, 1, 32'hFFFF_FFFE, 1, 0); waitDone();
        startOp(0, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF); waitDone();
        startOp(0, 1, 32'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 0, 32'd2); waitDone();
        startOp(0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 32'd14, 0, 32'hFFFF_FFFE); waitDone();
        // Multiply after a divide: remainder output must hold the divide's value
        startOp(1, 0, 32'd9, 32'd9, 1, 32'd81, 0, 0); waitDone();
        startOp(0, 1, 32'd5, 32'd0, 1, 32'h0, 1, 32'h0); waitDone();
        startOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 32'h0); waitDone();

        // Restart: aborted multiply must never strobe RDY
        startOp(1, 0, 32'd6, 32'd7, 0, 0, 0, 0);
        repeat (8) @(negedge clock);
        startOp(0, 1, 32'd84, 32'd4, 1, 32'd21, 0, 32'd0); waitDone();

        // Simultaneous starts: multiply wins
        startOp(1, 1, 32'd6, 32'd3, 1, 32'd18, 0, 0); waitDone();

        // Reset between edges in the middle of a multiply
        startOp(1, 0, 32'd12345, 32'd2, 0, 0, 0, 0);
        repeat (13) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check32("midreset_result", data_result, 32'h0);
        check32("midreset_exception", {31'b0, data_exception}, 32'h0);
        check32("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
`ifdef MULTDIV_REMAINDER_EN
        check32("midreset_remainder", data_remainder, 32'h0);
`endif
        lastRem = '0;
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (40) @(negedge clock);

        startOp(1, 0, 32'd2, 32'd2, 1, 32'd4, 0, 0); waitDone();

        checkInt("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
